// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry framer.
package telemetry_pkg;

  // Frame transmit states, in on-the-wire order.
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    DATA,
    CSUM
  } state_t;

  // Default start-of-frame marker.
  localparam logic [7:0] DEFAULT_HEADER = 8'h5A;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // Width of a byte index over n bytes, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running periodic tick: a one-cycle pulse every PERIOD clocks.
module tick_gen
  import telemetry_pkg::*;
#(
  parameter int PERIOD = 25000000
) (
  input  logic Clock,
  input  logic Reset,
  output logic tick
);

  localparam int CW = idx_width(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count_reg;

  // Counter runs 0..PERIOD-1 and wraps; nothing but reset restarts it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/telemetry_framer.sv
// Packs a payload snapshot into HEADER, seq, payload bytes (MSB first), XOR
// checksum, and streams it over a valid/ready byte interface.
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int         NUM_BYTES = 6,
  parameter int         PERIOD    = 25000000,
  parameter logic [7:0] HEADER    = DEFAULT_HEADER
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [8*NUM_BYTES-1:0] payload,
  input  logic                   alarm,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   overrun,
  output logic [7:0]             seq
);

  localparam int IW = idx_width(NUM_BYTES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BYTES - 1);

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [7:0]      seq_reg, seq_next;
  logic [7:0]      csum_reg, csum_next;
  logic            pending_reg, pending_next;
  logic            overrun_reg, overrun_next;
  logic            alarm_q;
  logic            tick;
  logic            alarm_edge;
  logic            trigger;
  logic            launch;
  logic [7:0]      cur_byte;
  logic [7:0]      pay_byte [NUM_BYTES];
  logic [7:0]      snap_reg [NUM_BYTES];

  tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick (
    .Clock(Clock),
    .Reset(Reset),
    .tick (tick)
  );

  assign alarm_edge = alarm && !alarm_q;
  assign trigger    = tick || alarm_edge;

  // Snapshot is taken at launch so the frame is self-consistent even if the
  // sensors update while bytes are still going out.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_snap
    assign pay_byte[gi] = payload[8*gi +: 8];

    // Load one snapshot byte when a frame launches.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        snap_reg[gi] <= '0;
      end else if (launch) begin
        snap_reg[gi] <= pay_byte[gi];
      end
    end
  end

  // Select the snapshot byte addressed by the current data index.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx_reg == IW'(i)) begin
        cur_byte = snap_reg[i];
      end
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: index, sequence, checksum, trigger bookkeeping.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_reg     <= '0;
      seq_reg     <= '0;
      csum_reg    <= '0;
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      idx_reg     <= idx_next;
      seq_reg     <= seq_next;
      csum_reg    <= csum_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      alarm_q     <= alarm;
    end
  end

  // Next-state, byte mux and checksum; a state moves only on an accepted byte.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    seq_next     = seq_reg;
    csum_next    = csum_reg;
    pending_next = pending_reg;
    overrun_next = overrun_reg;
    launch       = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = '0;

    case (state_reg)
      IDLE: begin
        if (trigger || pending_reg) begin
          launch       = 1'b1;
          pending_next = 1'b0;
          csum_next    = '0;
          state_next   = HDR;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) begin
          state_next = SEQ;
        end
      end
      SEQ: begin
        tx_valid = 1'b1;
        tx_data  = seq_reg;
        if (tx_ready) begin
          csum_next  = csum_reg ^ seq_reg;
          idx_next   = IDX_LAST;
          state_next = DATA;
        end
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready) begin
          csum_next = csum_reg ^ cur_byte;
          if (idx_reg == '0) begin
            state_next = CSUM;
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_reg;
        if (tx_ready) begin
          seq_next   = seq_reg + 8'd1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A trigger arriving mid-frame (CSUM-accept cycle included) is buffered
    // once; a second one while the buffer is full is lost and flagged.
    if (state_reg != IDLE && trigger) begin
      if (pending_reg) begin
        overrun_next = 1'b1;
      end else begin
        pending_next = 1'b1;
      end
    end
  end

  assign busy    = (state_reg != IDLE);
  assign overrun = overrun_reg;
  assign seq     = seq_reg;

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench: a PERIOD=16 instance for tick-driven frames and a
// PERIOD=1000 instance for alarm-driven frames, both NUM_BYTES=2.
module tb_telemetry_framer;

  logic        Clock;
  logic        Reset;
  logic [15:0] payload;
  logic        alarm;
  logic        tx_ready;

  logic [7:0]  a_data, b_data, a_seq, b_seq;
  logic        a_valid, b_valid, a_busy, b_busy, a_ovr, b_ovr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rst_cyc = 0;

  logic [7:0] rx [0:4];
  logic [7:0] exp_f [0:4];
  bit         rx_ok;
  int         rx_start, rx_end;

  telemetry_framer #(.NUM_BYTES(2), .PERIOD(16), .HEADER(8'h5A)) dut_a (
    .Clock(Clock), .Reset(Reset), .payload(payload), .alarm(1'b0),
    .tx_data(a_data), .tx_valid(a_valid), .tx_ready(tx_ready),
    .busy(a_busy), .overrun(a_ovr), .seq(a_seq)
  );

  telemetry_framer #(.NUM_BYTES(2), .PERIOD(1000), .HEADER(8'h5A)) dut_b (
    .Clock(Clock), .Reset(Reset), .payload(payload), .alarm(alarm),
    .tx_data(b_data), .tx_valid(b_valid), .tx_ready(tx_ready),
    .busy(b_busy), .overrun(b_ovr), .seq(b_seq)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic vsel(input bit s);
    return s ? b_valid : a_valid;
  endfunction

  function automatic logic [7:0] dsel(input bit s);
    return s ? b_data : a_data;
  endfunction

  task automatic set_exp(input logic [7:0] e0, e1, e2, e3, e4);
    exp_f[0] = e0; exp_f[1] = e1; exp_f[2] = e2; exp_f[3] = e3; exp_f[4] = e4;
  endtask

  // Two reset edges, released on a falling edge; rst_cyc marks the last one.
  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    rst_cyc = cyc;
  endtask

  // Waits for a frame and captures its 5 bytes (tx_ready held high); may
  // drive alarm / payload on chosen byte slots.
  task automatic recv_frame(input bit sel, input logic [4:0] rise_m,
                            input logic [4:0] fall_m, input logic [4:0] pl_m,
                            input logic [15:0] pl_v, input int budget);
    rx_ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge Clock);
      if (vsel(sel)) begin
        rx_ok = 1'b1;
        break;
      end
    end
    if (rx_ok) begin
      rx_start = cyc;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge Clock);
        if (!vsel(sel)) rx_ok = 1'b0;
        rx[i] = dsel(sel);
        if (fall_m[i]) alarm = 1'b0;
        if (rise_m[i]) alarm = 1'b1;
        if (pl_m[i]) payload = pl_v;
      end
      rx_end = cyc;
      $display("frame dut=%0d t=%0d bytes %h %h %h %h %h ok=%0d", sel, rx_start,
               rx[0], rx[1], rx[2], rx[3], rx[4], rx_ok);
    end else begin
      $display("frame dut=%0d none within %0d cycles", sel, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", a_valid); end
    vectors++; if (a_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", a_data); end
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", a_busy); end
    vectors++; if (a_ovr !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", a_ovr); end
    vectors++; if (a_seq !== 8'h00) begin miscompares++; $display("FAIL reset_seq got %h want 00", a_seq); end
    vectors++; if (b_valid !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL reset_b got valid=%b busy=%b want 0 0", b_valid, b_busy); end
    $display("reset checked at t=%0d", rst_cyc);
  endtask

  task automatic test_basic();
    do_reset();
    recv_frame(1'b0, 5'b0, 5'b0, 5'b0, 16'h0, 40);
    set_exp(8'h5A, 8'h00, 8'hA3, 8'h5C, 8'hFF);
    vectors++; if (!rx_ok) begin miscompares++; $display("FAIL basic_frame got none want frame"); end
    vectors++; if (rx_start !== rst_cyc + 16) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", rx_start - rst_cyc, 16); end
    vectors++; if (rx_end - rx_start !== 4) begin miscompares++; $display("FAIL basic_consecutive got span %0d want 4", rx_end - rx_start); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (rx[i] !== exp_f[i]) begin miscompares++; $display("FAIL basic_byte%0d got %h want %h", i, rx[i], exp_f[i]); end
    end
    @(negedge Clock);
    vectors++; if (a_seq !== 8'h01 || a_busy !== 1'b0) begin miscompares++; $display("FAIL basic_after got seq=%h busy=%b want 01 0", a_seq, a_busy); end
  endtask

  task automatic test_backpressure();
    bit seen;
    do_reset();
    set_exp(8'h5A, 8'h00, 8'hA3, 8'h5C, 8'hFF);
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge Clock);
      if (a_valid) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL bp_start got none want frame"); end
    if (seen) begin
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge Clock);
        vectors++; if (a_valid !== 1'b1 || a_data !== exp_f[i]) begin miscompares++; $display("FAIL bp_byte%0d got %b/%h want 1/%h", i, a_valid, a_data, exp_f[i]); end
        if (i == 2) begin
          tx_ready = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(negedge Clock);
            vectors++; if (a_valid !== 1'b1 || a_data !== 8'hA3 || a_seq !== 8'h00) begin miscompares++; $display("FAIL bp_hold%0d got %b/%h seq %h want 1/a3 seq 00", s, a_valid, a_data, a_seq); end
          end
          tx_ready = 1'b1;
        end
      end
      $display("backpressure frame done t=%0d", cyc);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit seen, early;
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge Clock);
      if (a_valid) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen || a_data !== 8'h5A) begin miscompares++; $display("FAIL rmf_start got %b/%h want 1/5a", seen, a_data); end
    @(negedge Clock);
    vectors++; if (a_data !== 8'h01) begin miscompares++; $display("FAIL rmf_seq got %h want 01", a_data); end
    @(negedge Clock);
    vectors++; if (a_data !== 8'hA3) begin miscompares++; $display("FAIL rmf_a3 got %h want a3", a_data); end
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    rst_cyc = cyc;
    vectors++; if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_seq !== 8'h00) begin miscompares++; $display("FAIL rmf_abort got valid=%b busy=%b seq=%h want 0 0 00", a_valid, a_busy, a_seq); end
    early = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(negedge Clock);
      if (a_valid) early = 1'b1;
    end
    vectors++; if (early) begin miscompares++; $display("FAIL rmf_quiet got valid before tick want none"); end
    @(negedge Clock);
    vectors++; if (a_valid !== 1'b1 || a_data !== 8'h5A) begin miscompares++; $display("FAIL rmf_restart_hdr got %b/%h want 1/5a", a_valid, a_data); end
    @(negedge Clock);
    vectors++; if (a_data !== 8'h00) begin miscompares++; $display("FAIL rmf_restart_seq got %h want 00", a_data); end
    $display("reset mid-frame done t=%0d", cyc);
  endtask

  task automatic test_alarm_across_reset();
    alarm = 1'b1;
    do_reset();
    recv_frame(1'b1, 5'b0, 5'b00001, 5'b0, 16'h0, 5);
    vectors++; if (!rx_ok || rx_start !== rst_cyc + 1) begin miscompares++; $display("FAIL held_alarm got ok=%0d at %0d want 1 at 1", rx_ok, rx_start - rst_cyc); end
    vectors++; if (rx[1] !== 8'h00 || rx[4] !== 8'hFF) begin miscompares++; $display("FAIL held_alarm_bytes got seq %h csum %h want 00 ff", rx[1], rx[4]); end
  endtask

  task automatic test_alarm_pending();
    int c0, end0;
    bit extra;
    do_reset();
    @(negedge Clock);
    alarm = 1'b1;
    c0 = cyc;
    recv_frame(1'b1, 5'b00100, 5'b00001, 5'b0, 16'h0, 10);
    end0 = rx_end;
    vectors++; if (!rx_ok || rx_start !== c0 + 1) begin miscompares++; $display("FAIL alarm_latency got ok=%0d lat %0d want 1 lat 1", rx_ok, rx_start - c0); end
    vectors++; if (rx[1] !== 8'h00 || rx[4] !== 8'hFF) begin miscompares++; $display("FAIL alarm_f0 got seq %h csum %h want 00 ff", rx[1], rx[4]); end
    recv_frame(1'b1, 5'b0, 5'b00001, 5'b0, 16'h0, 10);
    set_exp(8'h5A, 8'h01, 8'hA3, 8'h5C, 8'hFE);
    vectors++; if (!rx_ok || rx_start !== end0 + 2) begin miscompares++; $display("FAIL pending_gap got ok=%0d gap %0d want 1 gap 2", rx_ok, rx_start - end0); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (rx[i] !== exp_f[i]) begin miscompares++; $display("FAIL pending_byte%0d got %h want %h", i, rx[i], exp_f[i]); end
    end
    extra = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      if (b_busy) extra = 1'b1;
    end
    vectors++; if (extra || b_ovr !== 1'b0) begin miscompares++; $display("FAIL pending_tail got extra=%0d ovr=%b want 0 0", extra, b_ovr); end
  endtask

  task automatic test_overrun();
    bit extra;
    do_reset();
    @(negedge Clock);
    alarm = 1'b1;
    recv_frame(1'b1, 5'b01010, 5'b00101, 5'b00010, 16'h1234, 10);
    vectors++; if (!rx_ok || rx[2] !== 8'hA3 || rx[3] !== 8'h5C || rx[4] !== 8'hFF) begin miscompares++; $display("FAIL ovr_f0 got %h %h %h want a3 5c ff", rx[2], rx[3], rx[4]); end
    recv_frame(1'b1, 5'b0, 5'b00001, 5'b0, 16'h0, 10);
    set_exp(8'h5A, 8'h01, 8'h12, 8'h34, 8'h27);
    vectors++; if (!rx_ok) begin miscompares++; $display("FAIL ovr_f1 got none want frame"); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (rx[i] !== exp_f[i]) begin miscompares++; $display("FAIL ovr_byte%0d got %h want %h", i, rx[i], exp_f[i]); end
    end
    extra = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge Clock);
      if (b_busy) extra = 1'b1;
    end
    vectors++; if (extra) begin miscompares++; $display("FAIL ovr_single_extra got a third frame want none"); end
    vectors++; if (b_ovr !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", b_ovr); end
    do_reset();
    vectors++; if (b_ovr !== 1'b0) begin miscompares++; $display("FAIL ovr_cleared got %b want 0", b_ovr); end
    payload = 16'hA35C;
  endtask

  task automatic test_seq_wrap();
    int nbad;
    logic [7:0] es, s256, c256, s257, c257;
    do_reset();
    nbad = 0;
    s256 = 8'hxx; c256 = 8'hxx; s257 = 8'hxx; c257 = 8'hxx;
    for (int f = 1; f <= 257; f++) begin
      @(negedge Clock);
      alarm = 1'b1;
      recv_frame(1'b1, 5'b0, 5'b00001, 5'b0, 16'h0, 20);
      es = 8'(f - 1);
      if (!rx_ok || rx[0] !== 8'h5A || rx[1] !== es || rx[4] !== (es ^ 8'hA3 ^ 8'h5C)) nbad++;
      if (f == 256) begin s256 = rx[1]; c256 = rx[4]; end
      if (f == 257) begin s257 = rx[1]; c257 = rx[4]; end
    end
    vectors++; if (nbad !== 0) begin miscompares++; $display("FAIL wrap_all got %0d bad frames want 0", nbad); end
    vectors++; if (s256 !== 8'hFF || c256 !== 8'h00) begin miscompares++; $display("FAIL wrap_256 got seq %h csum %h want ff 00", s256, c256); end
    vectors++; if (s257 !== 8'h00 || c257 !== 8'hFF) begin miscompares++; $display("FAIL wrap_257 got seq %h csum %h want 00 ff", s257, c257); end
  endtask

  initial begin
    Reset = 1'b0;
    payload = 16'hA35C;
    alarm = 1'b0;
    tx_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_frame();
    test_alarm_across_reset();
    test_alarm_pending();
    test_overrun();
    test_seq_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/telemetry_framer.md
Name: telemetry_framer

Overview:
- Parametrised successor to the fixed once-per-second sensor report: packs N payload bytes into a framed, checksummed, sequence-numbered packet and streams it byte-by-byte to a UART byte transmitter over a valid/ready handshake.
- Frames launch on an internal periodic tick or on a rising edge of an alarm input, such as an accelerometer interrupt.
- One frame of pending-trigger buffering; overrun is flagged.
- Sits between the sensor front-ends (ultrasonic, ALS, accelerometer) and the Bluetooth UART.

Parameters:
- NUM_BYTES, 6, payload bytes per frame (1..16).
- PERIOD, 25000000, Clock cycles between periodic ticks (>=2).
- HEADER, 8'h5A, start-of-frame byte.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- payload  in  8*NUM_BYTES  sensor snapshot; byte NUM_BYTES-1 is in the MSBs and is sent first.
- alarm  in  1  level alarm; its rising edge requests an immediate frame.
- tx_data  out  8  byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts a byte when tx_valid && tx_ready.
- busy  out  1  a frame is in progress (state != IDLE).
- overrun  out  1  sticky: a trigger was lost.
- seq  out  8  sequence number of the next frame.

Behaviour:
- Reset (sync, Clock edge with Reset=1) clears:
  - outputs: tx_valid=0, tx_data=0, busy=0, overrun=0, seq=0;
  - internal: period counter=0, pending=0, alarm_q=0, state=IDLE.
- Reset mid-frame aborts the frame immediately; no partial bytes are sent afterwards.
- Tick: counter runs 0..PERIOD-1 and wraps. The tick is a 1-cycle pulse when the counter equals PERIOD-1. The counter is free-running and is not reset by alarm or frames.
- Alarm edge: alarm && !alarm_q, with alarm_q registered. Alarm held high across reset release produces an edge on the first cycle after reset.
- trigger = tick | alarm edge. Simultaneous tick and edge count as one trigger.
- Frame: HEADER, seq, payload[NUM_BYTES-1] .. payload[0], CSUM.
  - CSUM = XOR of seq and all payload bytes; the header is excluded.
  - Length is NUM_BYTES+3.
- States: IDLE -> HDR -> SEQ -> DATA (byte index NUM_BYTES-1 down to 0) -> CSUM -> IDLE.
  - A state advances only on the cycle tx_valid && tx_ready.
  - tx_valid=1 in every non-IDLE state.
  - tx_data and tx_valid hold stable until accepted; tx_valid never drops mid-frame except on reset.
- Launch: in IDLE, if trigger or pending, capture payload into an internal snapshot register, clear pending, and go to HDR.
  - tx_valid=1 with tx_data=HEADER on the next cycle, i.e. 1-cycle latency from trigger.
  - The payload is sampled at launch, not at trigger time.
- Trigger while busy, including the CSUM-accept cycle:
  - if pending=0, set pending=1;
  - if pending=1 already, set overrun=1 and drop the trigger.
- overrun clears only on reset.
- After CSUM is accepted: seq increments mod 256 (255->0) and the state returns to IDLE.
  - A pending frame launches from IDLE on the following cycle, giving one idle cycle between frames.
- CSUM accumulates incrementally as bytes are accepted. The accumulator is cleared at launch.

Decomposition:
- Package telemetry_pkg:
  - state enum (IDLE, HDR, SEQ, DATA, CSUM);
  - default header constant 8'h5A;
  - byte-index width function clog2(NUM_BYTES).
- Sub-module tick_gen(PERIOD): free-running counter with sync reset, outputs a 1-cycle tick. Reusable for other periodic reporting.
- Edge detect, pending/overrun logic, snapshot, byte mux and checksum stay in telemetry_framer.

Test Plan:
- Basic frame, NUM_BYTES=2, PERIOD=16, payload=16'hA35C, tx_ready=1:
  - first tick gives bytes 5A,00,A3,5C,FF on 5 consecutive accept cycles;
  - header valid 1 cycle after the tick; seq then reads 1.
- Backpressure: same setup, tx_ready low for 3 cycles during byte A3 -> tx_data stays A3 with tx_valid=1 throughout; the sequence is unchanged; checksum FF.
- Alarm during frame: PERIOD=1000, alarm rises mid-frame 0 -> pending. Next frame starts exactly 1 idle cycle after CSUM is accepted, with seq=01 and CSUM=01^A3^5C=FE. overrun stays 0.
- Overrun: two alarm edges during one busy frame -> exactly one extra frame follows, and overrun=1 stays until Reset.
- Seq wrap: run 257 frames -> frame 256 carries seq FF, frame 257 carries seq 00, and the checksum is correct in both.
- Reset mid-frame: assert Reset during byte A3 -> next cycle tx_valid=0, busy=0, seq=0, pending cleared. The next tick sends a full frame starting 5A,00.
